// File: rtl/btn_pulse_gen.sv
// btn_pulse_gen: synchronise, debounce and pulse-convert the S3 (x1) and S2 (x2) buttons
//   clk        system clock
//   rst        asynchronous active-high reset
//   btn_3      raw S3 button (x1), asynchronous
//   btn_2      raw S2 button (x2), asynchronous
//   x1_pulse   one-cycle pulse on an accepted, collision-free S3 press
//   x2_pulse   one-cycle pulse on an accepted, collision-free S2 press
//   x1_lvl     debounced S3 level
//   x2_lvl     debounced S2 level
//   both_err   sticky: a press rose together with, or while holding, the other button
//   pulse_cnt  wrapping count of emitted pulses
module btn_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_3,
    input  logic             btn_2,
    output logic             x1_pulse,
    output logic             x2_pulse,
    output logic             x1_lvl,
    output logic             x2_lvl,
    output logic             both_err,
    output logic [CNT_W-1:0] pulse_cnt
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    typedef enum logic {IDLE, ARMED} state_t;
    logic [1:0]    btn, s1, s;
    logic [CW-1:0] cnt   [2];
    state_t        st    [2];
    logic          lvl   [2];
    logic          rise  [2];
    logic          fall  [2];
    logic          pnext [2];
    logic          pulse [2];
    // channel 0 is x1 (S3), channel 1 is x2 (S2)
    assign btn = {btn_2, btn_3};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s  <= '0;
        end else begin
            s1 <= btn;
            s  <= s1;
        end
    end
    genvar k;
    for (k = 0; k < 2; k++) begin : g_ch
        assign lvl[k]   = st[k] == ARMED;
        // the level flips on the cycle the mismatch has persisted long enough
        assign rise[k]  = st[k] == IDLE  &&  s[k] && cnt[k] == CW'(DEBOUNCE_CYCLES - 1);
        assign fall[k]  = st[k] == ARMED && !s[k] && cnt[k] == CW'(DEBOUNCE_CYCLES - 1);
        // a press only pulses if the other button is neither held nor rising now
        assign pnext[k] = rise[k] && !lvl[1-k] && !rise[1-k];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st[k]    <= IDLE;
                cnt[k]   <= '0;
                pulse[k] <= 1'b0;
            end else begin
                pulse[k] <= pnext[k];
                cnt[k]   <= (s[k] == lvl[k] || rise[k] || fall[k]) ? '0 : cnt[k] + CW'(1);
                st[k]    <= rise[k] ? ARMED : fall[k] ? IDLE : st[k];
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            both_err  <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            if ((rise[0] && (lvl[1] || rise[1])) || (rise[1] && lvl[0]))
                both_err <= 1'b1;
            if (pnext[0] || pnext[1])
                pulse_cnt <= pulse_cnt + CNT_W'(1);
        end
    end
    assign x1_pulse = pulse[0];
    assign x2_pulse = pulse[1];
    assign x1_lvl   = lvl[0];
    assign x2_lvl   = lvl[1];
endmodule

// File: tb/tb_btn_pulse_gen.sv
// tb_btn_pulse_gen: directed checks of btn_pulse_gen with DEBOUNCE_CYCLES=4, CNT_W=3
module tb_btn_pulse_gen;
    logic       clk = 0, rst = 0, btn_3 = 0, btn_2 = 0;
    logic       x1_pulse, x2_pulse, x1_lvl, x2_lvl, both_err;
    logic [2:0] pulse_cnt;
    int         vec = 0, bad = 0, n1 = 0, n2 = 0;

    btn_pulse_gen #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .btn_3(btn_3), .btn_2(btn_2),
        .x1_pulse(x1_pulse), .x2_pulse(x2_pulse), .x1_lvl(x1_lvl), .x2_lvl(x2_lvl),
        .both_err(both_err), .pulse_cnt(pulse_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (x1_pulse) n1++;
        if (x2_pulse) n2++;
        vec++;
        if (x1_pulse && x2_pulse) begin
            bad++;
            $display("FAIL exclusive: x1_pulse=%b x2_pulse=%b required not both 1", x1_pulse, x2_pulse);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        btn_3 = 0;
        btn_2 = 0;
        rst   = 1;
        ticks(2);
        rst   = 0;
        n1    = 0;
        n2    = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        #1;
        vec++;
        if ({x1_pulse, x2_pulse, x1_lvl, x2_lvl, both_err, pulse_cnt} !== 8'b0) begin
            bad++;
            $display("FAIL reset: outputs=%b required 0", {x1_pulse, x2_pulse, x1_lvl, x2_lvl, both_err, pulse_cnt});
        end
        do_reset();
    endtask

    task automatic test_single_press();
        do_reset();
        btn_3 = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 4) begin
                vec++;
                if (x1_lvl !== 1'b0 || x1_pulse !== 1'b0) begin
                    bad++;
                    $display("FAIL early_lvl: x1_lvl=%b x1_pulse=%b required 0 0", x1_lvl, x1_pulse);
                end
            end
            if (i == 5) begin
                vec++;
                if (x1_lvl !== 1'b1 || x1_pulse !== 1'b1) begin
                    bad++;
                    $display("FAIL rise_edge5: x1_lvl=%b x1_pulse=%b required 1 1", x1_lvl, x1_pulse);
                end
            end
        end
        vec++;
        if (n1 !== 1 || n2 !== 0 || pulse_cnt !== 3'd1 || both_err !== 1'b0) begin
            bad++;
            $display("FAIL held: n1=%0d n2=%0d cnt=%0d err=%b required 1 0 1 0", n1, n2, pulse_cnt, both_err);
        end
        btn_3 = 0;
        ticks(10);
        vec++;
        if (x1_lvl !== 1'b0 || n1 !== 1) begin
            bad++;
            $display("FAIL release: x1_lvl=%b n1=%0d required 0 1", x1_lvl, n1);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            btn_2 = ~btn_2;
            ticks(2);
        end
        btn_2 = 0;
        ticks(10);
        vec++;
        if (x2_lvl !== 1'b0 || n2 !== 0 || pulse_cnt !== 3'd0) begin
            bad++;
            $display("FAIL bounce: x2_lvl=%b n2=%0d cnt=%0d required 0 0 0", x2_lvl, n2, pulse_cnt);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        btn_3 = 1;
        btn_2 = 1;
        ticks(10);
        vec++;
        if (n1 !== 0 || n2 !== 0 || both_err !== 1'b1 || x1_lvl !== 1'b1 || x2_lvl !== 1'b1) begin
            bad++;
            $display("FAIL simul: n1=%0d n2=%0d err=%b lvl=%b%b required 0 0 1 11", n1, n2, both_err, x1_lvl, x2_lvl);
        end
        btn_3 = 0;
        btn_2 = 0;
        ticks(10);
        vec++;
        if (both_err !== 1'b1 || x1_lvl !== 1'b0 || x2_lvl !== 1'b0 || pulse_cnt !== 3'd0) begin
            bad++;
            $display("FAIL sticky: err=%b lvl=%b%b cnt=%0d required 1 00 0", both_err, x1_lvl, x2_lvl, pulse_cnt);
        end
    endtask

    task automatic test_overlap();
        do_reset();
        btn_3 = 1;
        ticks(10);
        btn_2 = 1;
        ticks(10);
        btn_3 = 0;
        ticks(10);
        vec++;
        if (n1 !== 1 || n2 !== 0 || both_err !== 1'b1 || x2_lvl !== 1'b1 || x1_lvl !== 1'b0) begin
            bad++;
            $display("FAIL overlap: n1=%0d n2=%0d err=%b x1_lvl=%b x2_lvl=%b required 1 0 1 0 1", n1, n2, both_err, x1_lvl, x2_lvl);
        end
        btn_2 = 0;
        ticks(10);
    endtask

    task automatic press(input logic which);
        if (which) btn_2 = 1; else btn_3 = 1;
        ticks(8);
        btn_3 = 0;
        btn_2 = 0;
        ticks(8);
    endtask

    task automatic test_sequence();
        do_reset();
        press(0);
        vec++;
        if (n1 !== 1 || n2 !== 0) begin
            bad++;
            $display("FAIL seq_x1: n1=%0d n2=%0d required 1 0", n1, n2);
        end
        press(1);
        vec++;
        if (n1 !== 1 || n2 !== 1) begin
            bad++;
            $display("FAIL seq_x2a: n1=%0d n2=%0d required 1 1", n1, n2);
        end
        press(1);
        vec++;
        if (n1 !== 1 || n2 !== 2 || pulse_cnt !== 3'd3) begin
            bad++;
            $display("FAIL seq_x2b: n1=%0d n2=%0d cnt=%0d required 1 2 3", n1, n2, pulse_cnt);
        end
        for (int i = 0; i < 9; i++) press(i[0]);
        vec++;
        if (pulse_cnt !== 3'd4 || n1 + n2 !== 12 || both_err !== 1'b0) begin
            bad++;
            $display("FAIL wrap: cnt=%0d pulses=%0d err=%b required 4 12 0", pulse_cnt, n1 + n2, both_err);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        do_reset();
        btn_2 = 1;
        ticks(10);
        vec++;
        if (x2_lvl !== 1'b1 || n2 !== 1) begin
            bad++;
            $display("FAIL pre_rst: x2_lvl=%b n2=%0d required 1 1", x2_lvl, n2);
        end
        rst = 1;
        #1;
        vec++;
        if ({x1_pulse, x2_pulse, x1_lvl, x2_lvl, both_err, pulse_cnt} !== 8'b0) begin
            bad++;
            $display("FAIL mid_rst: outputs=%b required 0", {x1_pulse, x2_pulse, x1_lvl, x2_lvl, both_err, pulse_cnt});
        end
        tick();
        rst = 0;
        n2  = 0;
        lat = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (x2_pulse && lat == 0) lat = i;
        end
        vec++;
        if (lat !== 6 || n2 !== 1 || pulse_cnt !== 3'd1) begin
            bad++;
            $display("FAIL rearm: latency=%0d n2=%0d cnt=%0d required 6 1 1", lat, n2, pulse_cnt);
        end
        btn_2 = 0;
        ticks(10);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_simultaneous();
        test_overlap();
        test_sequence();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
